// File: rtl/multicycle_control_if.sv
// multicycle_control_if -- bundle between the multicycle controller and its datapath.
//   Inputs to the controller : op[6:0], funct3[2:0], Zero, mem_ready
//   Outputs from controller  : ImmSrc[1:0], isLUI, PCWrite, IRWrite, RegWrite,
//                              MemWrite, AdrSrc, ALUSrcA[1:0], ALUSrcB[1:0],
//                              ResultSrc[1:0], ALUOp[1:0], illegal
//   modport slave  : the controller
//   modport master : the datapath / testbench side
interface multicycle_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       mem_ready;

    logic [1:0] ImmSrc;
    logic       isLUI;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUOp;
    logic       illegal;

    modport slave (
        input  op, funct3, Zero, mem_ready,
        output ImmSrc, isLUI, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, illegal
    );

    modport master (
        output op, funct3, Zero, mem_ready,
        input  ImmSrc, isLUI, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control -- main FSM of a multicycle RV32 subset core.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high; loads FETCH and masks all write enables
//   bus   : multicycle_control_if.slave (opcode/flags in, datapath controls out)
// Optional build macro CTRL_MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE stall until
// mem_ready=1, and their write strobes fire only in the ready cycle. Without it,
// mem_ready is ignored and every state lasts one cycle.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.slave  bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_EXECL, S_ALUWB, S_BRANCH, S_JAL, S_JALR
    } state_t;

    // Per-state control word, registered alongside the state.
    // branch   : PCWrite comes from Zero/funct3 instead of pc_write
    // mem_wait : state talks to memory, strobes gated by mem_ready
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_wait;
    } ctl_t;

    function automatic ctl_t ctl_for(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write = 1'b1; c.pc_write = 1'b1;
                c.alu_src_b = 2'b10; c.result_src = 2'b10; c.mem_wait = 1'b1;
            end
            S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            S_MEMREAD:  begin c.adr_src = 1'b1; c.mem_wait = 1'b1; end
            S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; c.mem_wait = 1'b1; end
            S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.alu_op = 2'b10; end
            S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            S_EXECL:    begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
            S_ALUWB:    begin c.result_src = 2'b00; c.reg_write = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.alu_op = 2'b01;
                c.branch = 1'b1;
            end
            S_JAL:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
            S_JALR: begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.result_src = 2'b10;
                c.pc_write = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctl_t   ctl_q, ctl_d;
    logic   mem_ok;
    logic   op_known;
    logic   br_take;
    logic   gate;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        op_known = 1'b1;
        case (bus.op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU,
            OP_LUI, OP_BRANCH, OP_JAL, OP_JALR: op_known = 1'b1;
            default:                            op_known = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_IALU:           state_d = S_EXECI;
                    OP_LUI:            state_d = S_EXECL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ok ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ok ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_EXECL: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL, S_JALR: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
        ctl_d = ctl_for(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctl_q   <= ctl_for(S_FETCH);
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    // Only BEQ/BNE are supported; other funct3 never redirect the PC.
    assign br_take = ((bus.funct3 == 3'b000) &&  bus.Zero) ||
                     ((bus.funct3 == 3'b001) && !bus.Zero);
    assign gate    = !ctl_q.mem_wait || mem_ok;

    // Write strobes and illegal are masked combinationally by reset so they
    // stay low in the reset cycle whatever state the FSM happens to be in.
    assign bus.PCWrite  = !reset && (ctl_q.branch ? br_take : (ctl_q.pc_write && gate));
    assign bus.IRWrite  = !reset && ctl_q.ir_write && gate;
    assign bus.MemWrite = !reset && ctl_q.mem_write && gate;
    assign bus.RegWrite = !reset && ctl_q.reg_write;
    assign bus.illegal  = !reset && (state_q == S_DECODE) && !op_known;

    assign bus.AdrSrc    = ctl_q.adr_src;
    assign bus.ALUSrcA   = ctl_q.alu_src_a;
    assign bus.ALUSrcB   = ctl_q.alu_src_b;
    assign bus.ResultSrc = ctl_q.result_src;
    assign bus.ALUOp     = ctl_q.alu_op;

    // Immediate type follows the opcode in every state.
    always_comb begin
        bus.ImmSrc = 2'b00;
        bus.isLUI  = 1'b0;
        case (bus.op)
            OP_STORE:  bus.ImmSrc = 2'b01;
            OP_BRANCH: bus.ImmSrc = 2'b10;
            OP_JAL:    bus.ImmSrc = 2'b11;
            OP_LUI:    bus.isLUI  = 1'b1;
            default:   bus.ImmSrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control -- directed scenarios plus randomized instruction
// streams, checked every cycle against an instruction-class/step model.
module tb_multicycle_control;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef struct packed {
        logic [1:0] imm;
        logic       lui;
        logic       pcw, irw, rw, mw, adr;
        logic [1:0] a, b, res, aop;
        logic       ill;
    } out_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   step = 0;
    bit   model_on = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_if bus();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    // Instruction classes: 0 lw, 1 sw, 2 R, 3 I, 4 LUI, 5 branch, 6 JAL, 7 JALR, 8 illegal
    function automatic int cls_of(input logic [6:0] op);
        case (op)
            OP_LW:   return 0;
            OP_SW:   return 1;
            OP_R:    return 2;
            OP_I:    return 3;
            OP_LUI:  return 4;
            OP_BR:   return 5;
            OP_JAL:  return 6;
            OP_JALR: return 7;
            default: return 8;
        endcase
    endfunction

    function automatic int len_of(input int c);
        case (c)
            0:       return 5;
            5:       return 3;
            8:       return 2;
            default: return 4;
        endcase
    endfunction

    // Steps that touch memory: instruction fetch and the load/store access.
    function automatic bit is_mem_step(input int c, input int s);
        return (s == 0) || (s == 3 && (c == 0 || c == 1));
    endfunction

    function automatic bit ready_ok(input logic rdy);
`ifdef CTRL_MEM_WAIT_EN
        return rdy;
`else
        return 1'b1 | rdy;
`endif
    endfunction

    function automatic out_t model_out(input int c, input int s, input logic [6:0] op,
                                       input logic [2:0] f3, input logic z,
                                       input logic rdy, input logic rst);
        out_t e;
        bit   go;
        e  = '0;
        go = ready_ok(rdy);
        if (op == OP_SW)       e.imm = 2'd1;
        else if (op == OP_BR)  e.imm = 2'd2;
        else if (op == OP_JAL) e.imm = 2'd3;
        e.lui = (op == OP_LUI);
        if (s == 0) begin
            e.pcw = go; e.irw = go; e.b = 2'd2; e.res = 2'd2;
        end else if (s == 1) begin
            e.a = 2'd1; e.b = 2'd1; e.ill = (c == 8);
        end else if (s == 2) begin
            case (c)
                0, 1: begin e.a = 2'd2; e.b = 2'd1; end
                2:    begin e.a = 2'd2; e.b = 2'd0; e.aop = 2'd2; end
                3:    begin e.a = 2'd2; e.b = 2'd1; e.aop = 2'd2; end
                4:    begin e.a = 2'd3; e.b = 2'd1; end
                5: begin
                    e.a = 2'd2; e.aop = 2'd1;
                    e.pcw = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? !z : 1'b0);
                end
                6:    begin e.a = 2'd1; e.b = 2'd2; e.pcw = 1'b1; end
                7:    begin e.a = 2'd2; e.b = 2'd1; e.res = 2'd2; e.pcw = 1'b1; end
                default: ;
            endcase
        end else if (s == 3) begin
            if (c == 0)      e.adr = 1'b1;
            else if (c == 1) begin e.adr = 1'b1; e.mw = go; end
            else             e.rw = 1'b1;
        end else if (s == 4) begin
            e.res = 2'd1; e.rw = 1'b1;
        end
        if (rst) begin
            e.pcw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.mw = 1'b0; e.ill = 1'b0;
        end
        return e;
    endfunction

    function automatic out_t dut_out();
        out_t g;
        g.imm = bus.ImmSrc;   g.lui = bus.isLUI;
        g.pcw = bus.PCWrite;  g.irw = bus.IRWrite;
        g.rw  = bus.RegWrite; g.mw  = bus.MemWrite;
        g.adr = bus.AdrSrc;   g.a   = bus.ALUSrcA;
        g.b   = bus.ALUSrcB;  g.res = bus.ResultSrc;
        g.aop = bus.ALUOp;    g.ill = bus.illegal;
        return g;
    endfunction

    // Model advance: one step per edge unless a memory step is stalled.
    always @(posedge clk) begin
        if (reset) begin
            step     <= 0;
            model_on <= 1'b1;
        end else if (model_on) begin
            if (!(is_mem_step(cls_of(bus.op), step) && !ready_ok(bus.mem_ready)))
                step <= (step + 1 >= len_of(cls_of(bus.op))) ? 0 : step + 1;
        end
    end

    // Per-cycle compare.
    always @(negedge clk) begin
        if (model_on) begin
            out_t e, g;
            e = model_out(cls_of(bus.op), step, bus.op, bus.funct3, bus.Zero,
                          bus.mem_ready, reset);
            g = dut_out();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL cycle_check t=%0t op=%b step=%0d got=%h want=%h",
                         $time, bus.op, step, g, e);
            end
        end
    end

    task automatic lit(input string nm, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch();
        int n;
        n = 0;
        while (step != 0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL wait_fetch t=%0t got=step%0d want=step0", $time, step);
        end
    endtask

    initial begin
        bus.op = OP_LW; bus.funct3 = 3'd0; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        lit("reset_pcwrite", 8'(bus.PCWrite), 8'd0);
        lit("reset_irwrite", 8'(bus.IRWrite), 8'd0);
        repeat (2) tick();
        reset = 1'b0;

        // lw: five cycles, register write only in the last
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            lit("lw_regwrite", 8'(bus.RegWrite), 8'(c == 5));
            lit("lw_immsrc", 8'(bus.ImmSrc), 8'd0);
            if (c == 1) lit("lw_fetch_irwrite", 8'(bus.IRWrite), 8'd1);
            if (c == 5) lit("lw_wb_resultsrc", 8'(bus.ResultSrc), 8'd1);
            tick();
        end

        // beq taken, then not taken
        for (int k = 0; k < 2; k++) begin
            bus.op = OP_BR; bus.funct3 = 3'd0; bus.Zero = (k == 0);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                if (c == 3) begin
                    lit("beq_pcwrite", 8'(bus.PCWrite), 8'(k == 0));
                    lit("beq_immsrc", 8'(bus.ImmSrc), 8'd2);
                end
                tick();
            end
        end
        bus.Zero = 1'b0;

        // LUI
        bus.op = OP_LUI;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            lit("lui_islui", 8'(bus.isLUI), 8'd1);
            lit("lui_regwrite", 8'(bus.RegWrite), 8'(c == 4));
            if (c == 3) begin
                lit("lui_srca", 8'(bus.ALUSrcA), 8'd3);
                lit("lui_srcb", 8'(bus.ALUSrcB), 8'd1);
            end
            tick();
        end

        // illegal opcode: one pulse in DECODE, then FETCH
        bus.op = 7'b1111111;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            lit("illegal_pulse", 8'(bus.illegal), 8'(c == 2));
            if (c == 3) lit("illegal_then_fetch", 8'(bus.IRWrite), 8'd1);
            tick();
        end
        wait_fetch();

        // reset in MEMWRITE
        bus.op = OP_SW;
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        lit("rst_mw_memwrite", 8'(bus.MemWrite), 8'd0);
        lit("rst_mw_adrsrc", 8'(bus.AdrSrc), 8'd1);
        tick();
        @(negedge clk);
        lit("rst_fetch_irwrite", 8'(bus.IRWrite), 8'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        lit("post_rst_irwrite", 8'(bus.IRWrite), 8'd1);
        lit("post_rst_srcb", 8'(bus.ALUSrcB), 8'd2);
        tick();
        wait_fetch();

`ifdef CTRL_MEM_WAIT_EN
        // sw with three not-ready cycles in MEMWRITE: seven cycles in all
        bus.op = OP_SW;
        for (int c = 1; c <= 8; c++) begin
            bus.mem_ready = !(c >= 4 && c <= 6);
            @(negedge clk);
            if (c >= 4 && c <= 7) lit("wait_sw_memwrite", 8'(bus.MemWrite), 8'(c == 7));
            if (c == 8) lit("wait_sw_next_fetch", 8'(bus.IRWrite), 8'd1);
            tick();
        end
        bus.mem_ready = 1'b1;
        wait_fetch();
`endif

        // randomized instruction stream
        for (int i = 0; i < 800; i++) begin
            if (step == 0) begin
                int r;
                r = int'($urandom_range(0, 9));
                case (r)
                    0: bus.op = OP_LW;   1: bus.op = OP_SW;
                    2: bus.op = OP_R;    3: bus.op = OP_I;
                    4: bus.op = OP_LUI;  5: bus.op = OP_BR;
                    6: bus.op = OP_JAL;  7: bus.op = OP_JALR;
                    default: bus.op = 7'($urandom);
                endcase
                r = int'($urandom_range(0, 7));
                bus.funct3 = (r < 6) ? 3'(r % 2) : 3'($urandom);
            end
            bus.Zero      = 1'($urandom);
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            reset         = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
